// File: rtl/bsk_cmd_scan_if.sv
// Shared command-bus bundle between the two-bank input scanner and the board/consumer side.
// Carries the buffer bus, both buffer enables, the filtered command word and the frame/change strobes.
interface bsk_cmd_scan_if;
    logic [15:0] bus;
    logic        oe0_n;
    logic        oe1_n;
    logic [31:0] com;
    logic        scan_done;
    logic        change;

    modport master (
        input  bus,
        output oe0_n, oe1_n, com, scan_done, change
    );

    modport slave (
        output bus,
        input  oe0_n, oe1_n, com, scan_done, change
    );
endinterface

// File: rtl/bsk_cmd_scan.sv
// Scans two banks of 16 active-low command inputs over one shared bus and debounces them per bit.
// Latency: a steady input appears on com DEB frames after its first sample, at its bank's GAP exit.
// Backpressure: none; the scan free-runs with a frame period of 2*SETTLE+4 cycles.
module bsk_cmd_scan #(
    parameter int unsigned SETTLE = 2,
    parameter int unsigned DEB    = 3
) (
    input  logic           clk,
    input  logic           rst_n,
    bsk_cmd_scan_if.master sb
);

    typedef enum logic [1:0] {EN0, GAP0, EN1, GAP1} state_t;

    state_t           state_q;
    state_t           state_d;
    logic [3:0]       cyc_q;
    logic [15:0]      raw0_q;
    logic [15:0]      raw1_q;
    logic [31:0]      com_q;
    logic [31:0]      com_d;
    logic [31:0][3:0] cnt_q;
    logic [31:0][3:0] cnt_d;
    logic             scan_done_q;
    logic             change_q;
    logic             sample_end;
    logic [31:0]      raw_all;
    logic [31:0]      bank_en;

    assign sample_end = (cyc_q == 4'(SETTLE));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= GAP1;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EN0:     if (sample_end) state_d = GAP0;
            GAP0:    state_d = EN1;
            EN1:     if (sample_end) state_d = GAP1;
            GAP1:    state_d = EN0;
            default: state_d = GAP1;
        endcase
    end

    // Enables decode straight from the state register, so they drop to 1 the moment reset asserts.
    always_comb begin
        sb.oe0_n = 1'b1;
        sb.oe1_n = 1'b1;
        case (state_q)
            EN0:     sb.oe0_n = 1'b0;
            EN1:     sb.oe1_n = 1'b0;
            default: ;
        endcase
    end

    // Each GAP cycle is the filter edge for the bank that was just sampled.
    assign raw_all = {raw1_q, raw0_q};
    assign bank_en = {{16{state_q == GAP1}}, {16{state_q == GAP0}}};

    always_comb begin
        com_d = com_q;
        cnt_d = cnt_q;
        for (int i = 0; i < 32; i++) begin
            if (bank_en[i]) begin
                if (raw_all[i] == com_q[i]) begin
                    cnt_d[i] = 4'd0;
                end else if (cnt_q[i] == 4'(DEB - 1)) begin
                    com_d[i] = raw_all[i];
                    cnt_d[i] = 4'd0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q       <= 4'd0;
            raw0_q      <= 16'd0;
            raw1_q      <= 16'd0;
            com_q       <= 32'd0;
            cnt_q       <= '0;
            scan_done_q <= 1'b0;
            change_q    <= 1'b0;
        end else begin
            if ((state_q == EN0 || state_q == EN1) && !sample_end) begin
                cyc_q <= cyc_q + 4'd1;
            end else begin
                cyc_q <= 4'd0;
            end
            if (state_q == EN0 && sample_end) raw0_q <= ~sb.bus;
            if (state_q == EN1 && sample_end) raw1_q <= ~sb.bus;
            com_q       <= com_d;
            cnt_q       <= cnt_d;
            change_q    <= (com_d != com_q);
            scan_done_q <= (state_q == GAP1);
        end
    end

    assign sb.com       = com_q;
    assign sb.scan_done = scan_done_q;
    assign sb.change    = change_q;

endmodule
